// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the serial frame bridge.
// State encoding, default command codes and the bit-counter width helper.
package spi_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WR_REQ,
        RD_REQ,
        RD_WAIT,
        TX,
        DRAIN
    } state_t;

    localparam logic [7:0] DEF_CMD_WR = 8'hFF;
    localparam logic [7:0] DEF_CMD_RD = 8'h0F;

    // Counter must hold FRAME_W+1 (the optional parity bit) without wrapping.
    function automatic int cnt_width(input int frame_w);
        return $clog2(frame_w + 2);
    endfunction

endpackage

// File: rtl/spi_frame_bridge_tx.sv
// Read-data serialiser: loads a DATA_W word and emits it LSB-first.
// With SPI_FRAME_PARITY_EN defined an even-parity bit follows the data bits.
module spi_tx_shifter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              shift,
    output logic              bit_out,
    output logic              last
);

`ifdef SPI_FRAME_PARITY_EN
    localparam int TX_BITS = DATA_W + 1;
`else
    localparam int TX_BITS = DATA_W;
`endif
    localparam int CW = $clog2(TX_BITS + 1);

    logic [DATA_W-1:0] sreg;
    logic [CW-1:0]     cnt;
`ifdef SPI_FRAME_PARITY_EN
    logic              par;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
`ifdef SPI_FRAME_PARITY_EN
            par  <= 1'b0;
`endif
        end else if (load) begin
            sreg <= data;
            cnt  <= '0;
`ifdef SPI_FRAME_PARITY_EN
            par  <= ^data;
`endif
        end else if (shift) begin
            sreg <= sreg >> 1;
            cnt  <= cnt + CW'(1);
        end
    end

`ifdef SPI_FRAME_PARITY_EN
    assign bit_out = (cnt == CW'(DATA_W)) ? par : sreg[0];
`else
    assign bit_out = sreg[0];
`endif
    assign last = (cnt == CW'(TX_BITS - 1));

endmodule

// File: rtl/spi_frame_bridge.sv
// Serial frame to parallel bus bridge: {cmd, addr, data} frames become bus writes or reads.
// Optional trailing even-parity bit on frames and read data when SPI_FRAME_PARITY_EN is defined.
module spi_frame_bridge
    import spi_frame_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter int                ADDR_W = 24,
    parameter int                CMD_W  = 8,
    parameter logic [CMD_W-1:0]  CMD_WR = {CMD_W{1'b1}},
    parameter logic [CMD_W-1:0]  CMD_RD = CMD_W'(DEF_CMD_RD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              sdi,
    output logic              sdo,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_rdata,
    input  logic              rd_rvalid,
    output logic              frame_err,
    output logic              cmd_err,
    output logic              busy
);

    localparam int FRAME_W = DATA_W + ADDR_W + CMD_W;
`ifdef SPI_FRAME_PARITY_EN
    localparam int NBITS = FRAME_W + 1;
`else
    localparam int NBITS = FRAME_W;
`endif
    localparam int CNT_W = cnt_width(FRAME_W);

    state_t             state, state_nx;
    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   cnt;
    logic               frame_done;
    logic [CMD_W-1:0]   cmd;
    logic               par_ok;
    logic               frame_err_nx, cmd_err_nx;
    logic               tx_load, tx_bit, tx_last;

    assign frame_done = (cnt == CNT_W'(NBITS));
    assign cmd        = shreg[FRAME_W-1 -: CMD_W];

`ifdef SPI_FRAME_PARITY_EN
    logic par_bit;
    assign par_ok = ~((^shreg) ^ par_bit);
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Frame capture; bits arriving after the frame is complete are never shifted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            cnt       <= '0;
            frame_err <= 1'b0;
            cmd_err   <= 1'b0;
`ifdef SPI_FRAME_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            frame_err <= frame_err_nx;
            cmd_err   <= cmd_err_nx;
            if (state == IDLE && cs) begin
                shreg <= {sdi, shreg[FRAME_W-1:1]};
                cnt   <= CNT_W'(1);
            end else if (state == SHIFT && cs && !frame_done) begin
`ifdef SPI_FRAME_PARITY_EN
                if (cnt == CNT_W'(FRAME_W)) par_bit <= sdi;
                else                        shreg   <= {sdi, shreg[FRAME_W-1:1]};
`else
                shreg <= {sdi, shreg[FRAME_W-1:1]};
`endif
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx     = state;
        frame_err_nx = 1'b0;
        cmd_err_nx   = 1'b0;
        case (state)
            IDLE:    if (cs) state_nx = SHIFT;
            SHIFT: begin
                if (frame_done) begin
                    if (!par_ok) begin
                        frame_err_nx = 1'b1;
                        state_nx     = DRAIN;
                    end else if (cmd == CMD_WR) begin
                        state_nx = WR_REQ;
                    end else if (cmd == CMD_RD) begin
                        state_nx = RD_REQ;
                    end else begin
                        cmd_err_nx = 1'b1;
                        state_nx   = DRAIN;
                    end
                end else if (!cs) begin
                    frame_err_nx = 1'b1;
                    state_nx     = IDLE;
                end
            end
            WR_REQ:  if (wr_ready) state_nx = DRAIN;
            RD_REQ:  if (rd_ready) state_nx = RD_WAIT;
            RD_WAIT: begin
                if (!cs)            state_nx = DRAIN;
                else if (rd_rvalid) state_nx = TX;
            end
            TX: begin
                if (!cs) begin
                    frame_err_nx = 1'b1;
                    state_nx     = IDLE;
                end else if (tx_last) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN:   if (!cs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wr_valid = (state == WR_REQ);
        rd_valid = (state == RD_REQ);
        busy     = (state != IDLE);
        sdo      = (state == TX) && cs && tx_bit;
        tx_load  = (state == RD_WAIT) && cs && rd_rvalid;
    end

    assign wr_addr = shreg[DATA_W +: ADDR_W];
    assign wr_data = shreg[DATA_W-1:0];
    assign rd_addr = shreg[DATA_W +: ADDR_W];

    spi_tx_shifter #(.DATA_W(DATA_W)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tx_load),
        .data    (rd_rdata),
        .shift   (state == TX),
        .bit_out (tx_bit),
        .last    (tx_last)
    );

endmodule

// File: tb/tb_spi_frame_bridge.sv
// Directed bench for spi_frame_bridge: table of frames plus hand-written corner sequences.
// Covers the parity variant when SPI_FRAME_PARITY_EN is defined.
module tb_spi_frame_bridge;

    logic        clk = 1'b0;
    logic        rst_n, cs, sdi, sdo;
    logic        wr_valid, wr_ready, rd_valid, rd_ready, rd_rvalid;
    logic [23:0] wr_addr, rd_addr;
    logic [31:0] wr_data, rd_rdata;
    logic        frame_err, cmd_err, busy;

    int checks = 0;
    int errors = 0;
    int wr_acc = 0, rd_acc = 0, wr_seen = 0, rd_seen = 0, fe_cnt = 0, ce_cnt = 0;

    spi_frame_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .sdi       (sdi),
        .sdo       (sdo),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rd_rdata  (rd_rdata),
        .rd_rvalid (rd_rvalid),
        .frame_err (frame_err),
        .cmd_err   (cmd_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_valid && wr_ready) wr_acc <= wr_acc + 1;
        if (rd_valid && rd_ready) rd_acc <= rd_acc + 1;
        if (wr_valid)             wr_seen <= wr_seen + 1;
        if (rd_valid)             rd_seen <= rd_seen + 1;
        if (frame_err)            fe_cnt <= fe_cnt + 1;
        if (cmd_err)              ce_cnt <= ce_cnt + 1;
    end

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [31:0] data;
        logic        exp_wr;
        logic        exp_rd;
        logic        exp_ce;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d);
        return {c, a, d};
    endfunction

    task automatic send_bits(input logic [63:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            cs  = 1'b1;
            sdi = f[i];
            step();
        end
        sdi = 1'b0;
    endtask

`ifdef SPI_FRAME_PARITY_EN
    task automatic send_parity(input logic [63:0] f, input logic flip);
        cs  = 1'b1;
        sdi = (^f) ^ flip;
        step();
        sdi = 1'b0;
    endtask
`endif

    task automatic send_full(input logic [63:0] f);
        send_bits(f, 64);
`ifdef SPI_FRAME_PARITY_EN
        send_parity(f, 1'b0);
`endif
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int wa0, ra0, ce0;
        wa0 = wr_acc;
        ra0 = rd_acc;
        ce0 = ce_cnt;
        send_full(mk(v.cmd, v.addr, v.data));
        chk($sformatf("vec%0d_decode_cycle_valids", idx), {wr_valid, rd_valid}, 0);
        step();
        chk($sformatf("vec%0d_wr_valid", idx), wr_valid, v.exp_wr);
        chk($sformatf("vec%0d_rd_valid", idx), rd_valid, v.exp_rd);
        if (v.exp_wr) begin
            chk($sformatf("vec%0d_wr_addr", idx), wr_addr, v.addr);
            chk($sformatf("vec%0d_wr_data", idx), wr_data, v.data);
        end
        if (v.exp_rd) chk($sformatf("vec%0d_rd_addr", idx), rd_addr, v.addr);
        wr_ready = 1'b1;
        rd_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        rd_ready = 1'b0;
        cs = 1'b0;
        step();
        step();
        rd_rvalid = 1'b1;
        rd_rdata  = 32'hFFFF_FFFF;
        step();
        rd_rvalid = 1'b0;
        chk($sformatf("vec%0d_sdo_idle", idx), sdo, 1'b0);
        chk($sformatf("vec%0d_busy_idle", idx), busy, 1'b0);
        chk($sformatf("vec%0d_writes", idx), wr_acc - wa0, v.exp_wr);
        chk($sformatf("vec%0d_reads", idx), rd_acc - ra0, v.exp_rd);
        chk($sformatf("vec%0d_cmd_errs", idx), ce_cnt - ce0, v.exp_ce);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rdat;
        logic [63:0] f;
        int          wa0, fe0, ws0, rs0, ce0;

        vecs[0] = '{8'hFF, 24'hABCDEF, 32'h0123_4567, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h0F, 24'h000010, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 24'h5A5A5A, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 24'hFFFFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h0F, 24'hFFFFFF, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'hFE, 24'h000001, 32'h0000_0001, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 24'h000000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h0E, 24'h800000, 32'h8000_0000, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; cs = 1'b0; sdi = 1'b0;
        wr_ready = 1'b0; rd_ready = 1'b0; rd_rvalid = 1'b0; rd_rdata = '0;
        repeat (3) step();
        chk("reset_ctrl", {wr_valid, rd_valid, sdo, busy, frame_err, cmd_err}, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_wr_data", wr_data, 0);
        chk("reset_rd_addr", rd_addr, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Write with a three-cycle bus stall.
        wa0 = wr_acc;
        send_full(mk(8'hFF, 24'h123456, 32'hDEAD_BEEF));
        chk("wr_valid_early", wr_valid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("wr_stall%0d_valid", k), wr_valid, 1'b1);
            chk($sformatf("wr_stall%0d_addr", k), wr_addr, 24'h123456);
            chk($sformatf("wr_stall%0d_data", k), wr_data, 32'hDEAD_BEEF);
        end
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        chk("wr_valid_drop", wr_valid, 1'b0);
        chk("wr_single_accept", wr_acc - wa0, 1);
        chk("wr_busy_drain", busy, 1'b1);
        cs = 1'b0;
        step();
        chk("wr_busy_after_cs", busy, 1'b0);
        step();

        // Read returning A5A5A5A5 two cycles after the request is taken.
        rdat = 32'hA5A5_A5A5;
        send_full(mk(8'h0F, 24'h000010, 32'h0));
        step();
        chk("rd_valid", rd_valid, 1'b1);
        chk("rd_addr", rd_addr, 24'h000010);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("rd_valid_drop", rd_valid, 1'b0);
        step();
        chk("rd_wait_sdo", sdo, 1'b0);
        step();
        rd_rvalid = 1'b1;
        rd_rdata  = rdat;
        step();
        rd_rvalid = 1'b0;
        rd_rdata  = '0;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("rd_sdo_bit%0d", i), sdo, rdat[i]);
            step();
        end
`ifdef SPI_FRAME_PARITY_EN
        chk("rd_sdo_parity", sdo, ^rdat);
        step();
`endif
        chk("rd_sdo_after", sdo, 1'b0);
        chk("rd_busy_drain", busy, 1'b1);
        cs = 1'b0;
        step();
        chk("rd_busy_after_cs", busy, 1'b0);
        step();

        // Abort after 40 bits.
        fe0 = fe_cnt; ws0 = wr_seen; rs0 = rd_seen;
        send_bits(mk(8'hFF, 24'h111111, 32'h2222_2222), 40);
        cs = 1'b0;
        step();
        chk("abort_frame_err", frame_err, 1'b1);
        step();
        chk("abort_frame_err_pulse", frame_err, 1'b0);
        chk("abort_fe_count", fe_cnt - fe0, 1);
        chk("abort_no_wr", wr_seen - ws0, 0);
        chk("abort_no_rd", rd_seen - rs0, 0);
        chk("abort_busy", busy, 1'b0);
        run_vec(vecs[0], 100);

        // Bad command followed by extra bits while cs stays high.
        ce0 = ce_cnt; ws0 = wr_seen; rs0 = rd_seen;
        send_full(mk(8'h3C, 24'h000020, 32'h1234_5678));
        for (int i = 0; i < 6; i++) begin
            cs  = 1'b1;
            sdi = 1'b1;
            step();
        end
        sdi = 1'b0;
        cs  = 1'b0;
        step();
        step();
        chk("badcmd_single_err", ce_cnt - ce0, 1);
        chk("badcmd_no_wr", wr_seen - ws0, 0);
        chk("badcmd_no_rd", rd_seen - rs0, 0);
        chk("badcmd_busy", busy, 1'b0);

        // Reset while the read data is on sdo.
        send_full(mk(8'h0F, 24'h000040, 32'h0));
        step();
        rd_ready = 1'b1;
        step();
        rd_ready  = 1'b0;
        rd_rvalid = 1'b1;
        rd_rdata  = rdat;
        step();
        rd_rvalid = 1'b0;
        repeat (10) step();
        chk("rst_pre_sdo_bit10", sdo, rdat[10]);
        rst_n = 1'b0;
        cs    = 1'b0;
        #1;
        chk("rst_mid_tx_outs", {sdo, busy, wr_valid, rd_valid}, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        run_vec(vecs[3], 101);

`ifdef SPI_FRAME_PARITY_EN
        // Flipped parity bit must reject the frame; correct parity writes.
        wa0 = wr_acc;
        fe0 = fe_cnt;
        f   = mk(8'hFF, 24'h0A0B0C, 32'h1122_3344);
        send_bits(f, 64);
        send_parity(f, 1'b1);
        step();
        chk("par_bad_frame_err", frame_err, 1'b1);
        chk("par_bad_no_wr_valid", wr_valid, 1'b0);
        cs = 1'b0;
        step();
        step();
        chk("par_bad_no_write", wr_acc - wa0, 0);
        chk("par_bad_fe_count", fe_cnt - fe0, 1);
        run_vec('{8'hFF, 24'h0A0B0C, 32'h1122_3344, 1'b1, 1'b0, 1'b0}, 102);
`else
        f = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
